// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the EX-stage issue logic and the multiply/divide unit.
// The master drives a one-cycle Start with its op and operands; the slave returns Busy and HI/LO.
interface mult_div_unit_if;
   logic        Start;
   logic [2:0]  MDOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (output Start, MDOp, A, B, input Busy, HI, LO);
   modport slave  (input Start, MDOp, A, B, output Busy, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// MIPS multiply/divide unit: the result is computed at accept time and held in pending
// registers, then committed to HI/LO when the busy countdown expires.
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   mult_div_unit_if.slave   md
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } md_op_e;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic [31:0]      phi_q, phi_d;
   logic [31:0]      plo_q, plo_d;

   logic        is_signed;
   logic [63:0] prod;
   logic [31:0] abs_a, abs_b, div_b, q_mag, r_mag, quo, rem;
   logic        neg_q, neg_r;
   logic        busy;

   assign busy = (cnt_q != '0);

   // Signed variants share the unsigned datapath: sign-extend for the product,
   // and divide magnitudes then restore signs (truncation toward zero).
   always_comb begin
      is_signed = (md.MDOp == OP_MULT) || (md.MDOp == OP_DIV);
      prod      = {{32{is_signed & md.A[31]}}, md.A} * {{32{is_signed & md.B[31]}}, md.B};
      abs_a     = (is_signed && md.A[31]) ? (32'd0 - md.A) : md.A;
      abs_b     = (is_signed && md.B[31]) ? (32'd0 - md.B) : md.B;
      div_b     = (abs_b == 32'd0) ? 32'd1 : abs_b;
      q_mag     = abs_a / div_b;
      r_mag     = abs_a % div_b;
      neg_q     = is_signed & (md.A[31] ^ md.B[31]);
      neg_r     = is_signed & md.A[31];
      quo       = neg_q ? (32'd0 - q_mag) : q_mag;
      rem       = neg_r ? (32'd0 - r_mag) : r_mag;
   end

   always_comb begin
      cnt_d = cnt_q;
      hi_d  = hi_q;
      lo_d  = lo_q;
      phi_d = phi_q;
      plo_d = plo_q;
      if (busy) begin
         // Start while busy is dropped on the floor; only the countdown advances.
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            hi_d = phi_q;
            lo_d = plo_q;
         end
      end else if (md.Start) begin
         case (md.MDOp)
            OP_MULT, OP_MULTU: begin
               phi_d = prod[63:32];
               plo_d = prod[31:0];
               cnt_d = CNT_W'(MULT_CYCLES);
            end
            OP_DIV, OP_DIVU: begin
               if (md.B != 32'd0) begin
                  phi_d = rem;
                  plo_d = quo;
                  cnt_d = CNT_W'(DIV_CYCLES);
               end
            end
            OP_MTHI: hi_d = md.A;
            OP_MTLO: lo_d = md.A;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         phi_q <= '0;
         plo_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         phi_q <= phi_d;
         plo_q <= plo_d;
      end
   end

   assign md.Busy = busy;
   assign md.HI   = hi_q;
   assign md.LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO values and cycle-exact Busy windows.
module tb_mult_div_unit;
   logic clk;
   logic reset;
   int   n_chk;
   int   n_fail;
   logic [31:0] cur_hi, cur_lo;

   mult_div_unit_if mif();

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (mif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Presents one Start at a negedge; returns at the negedge after the accept edge,
   // with the operand bus scrambled so late sampling would show up.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      mif.Start = 1'b1; mif.MDOp = op; mif.A = a; mif.B = b;
      @(negedge clk);
      mif.Start = 1'b0; mif.MDOp = 3'd7; mif.A = $urandom; mif.B = $urandom;
   endtask

   task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int cyc, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input bit intrude);
      issue(op, a, b);
      for (int k = 0; k < cyc; k++) begin
         chk({nm, "_busy"}, {31'd0, mif.Busy}, 32'd1);
         chk({nm, "_hi_old"}, mif.HI, cur_hi);
         chk({nm, "_lo_old"}, mif.LO, cur_lo);
         if (intrude && k == 1) begin
            mif.Start = 1'b1; mif.MDOp = 3'd0; mif.A = 32'd3; mif.B = 32'd3;
         end
         if (intrude && k == 2) mif.Start = 1'b0;
         @(negedge clk);
      end
      chk({nm, "_done_busy"}, {31'd0, mif.Busy}, 32'd0);
      chk({nm, "_hi"}, mif.HI, exp_hi);
      chk({nm, "_lo"}, mif.LO, exp_lo);
      cur_hi = exp_hi;
      cur_lo = exp_lo;
      @(negedge clk);
      chk({nm, "_after_busy"}, {31'd0, mif.Busy}, 32'd0);
      chk({nm, "_after_hi"}, mif.HI, cur_hi);
      chk({nm, "_after_lo"}, mif.LO, cur_lo);
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      cur_hi = 32'd0; cur_lo = 32'd0;
      mif.Start = 1'b0; mif.MDOp = 3'd7; mif.A = 32'd0; mif.B = 32'd0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, mif.Busy}, 32'd0);
      chk("rst_hi", mif.HI, 32'd0);
      chk("rst_lo", mif.LO, 32'd0);
      reset = 1'b0;

      run_op("mult",  3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
      run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 5,  32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
      run_op("div",   3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

      issue(3'd3, 32'd7, 32'd0);
      for (int k = 0; k < 3; k++) begin
         chk("divz_busy", {31'd0, mif.Busy}, 32'd0);
         chk("divz_hi", mif.HI, cur_hi);
         chk("divz_lo", mif.LO, cur_lo);
         @(negedge clk);
      end

      run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000, 1'b0);

      @(negedge clk);
      mif.Start = 1'b1; mif.MDOp = 3'd4; mif.A = 32'h1234_5678;
      @(negedge clk);
      chk("mthi_hi", mif.HI, 32'h1234_5678);
      chk("mthi_lo", mif.LO, cur_lo);
      chk("mthi_busy", {31'd0, mif.Busy}, 32'd0);
      mif.MDOp = 3'd5; mif.A = 32'h9ABC_DEF0;
      @(negedge clk);
      mif.Start = 1'b0;
      chk("mtlo_lo", mif.LO, 32'h9ABC_DEF0);
      chk("mtlo_hi", mif.HI, 32'h1234_5678);
      chk("mtlo_busy", {31'd0, mif.Busy}, 32'd0);
      cur_hi = 32'h1234_5678; cur_lo = 32'h9ABC_DEF0;

      run_op("mult_ign", 3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);

      issue(3'd2, 32'd100, 32'd7);
      repeat (2) @(negedge clk);
      chk("rstdiv_busy_pre", {31'd0, mif.Busy}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("rstdiv_busy", {31'd0, mif.Busy}, 32'd0);
      chk("rstdiv_hi", mif.HI, 32'd0);
      chk("rstdiv_lo", mif.LO, 32'd0);
      @(negedge clk);
      mif.Start = 1'b1; mif.MDOp = 3'd4; mif.A = 32'h0000_0055;
      @(negedge clk);
      mif.Start = 1'b0;
      chk("rst_start_hi", mif.HI, 32'd0);
      reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk("postrst_busy", {31'd0, mif.Busy}, 32'd0);
         chk("postrst_hi", mif.HI, 32'd0);
         chk("postrst_lo", mif.LO, 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
